uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 96 +++++++++
 tb/tb_uart_tx_fifo.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed by a small circular FIFO.
// Ports: clk/reset (sync, active-high); tx_start/tx_byte push a word when tx_ready;
// tx_serial is the line (idle high, LSB first); tx_busy = frame running or FIFO
// non-empty; tx_ready = FIFO not full; fifo_count = occupancy; tx_overflow pulses
// while tx_start is asserted against a full FIFO.
module uart_tx_fifo #(
   parameter int CLKS_PER_BIT = 5208,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          tx_start,
   input  logic [DATA_BITS-1:0]          tx_byte,
   output logic                          tx_serial,
   output logic                          tx_busy,
   output logic                          tx_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          tx_overflow
);
   localparam int AW = $clog2(FIFO_DEPTH);
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
   state_t state, state_n;
   logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [15:0] bit_cnt;
   logic [3:0] bit_idx;
   logic [DATA_BITS-1:0] shift;
   logic par_bit, push, pop, bit_end;

   assign tx_ready    = fifo_count < (AW+1)'(FIFO_DEPTH);
   assign push        = tx_start && tx_ready && !reset;
   assign tx_overflow = tx_start && !tx_ready && !reset;
   assign tx_busy     = state != S_IDLE || fifo_count != '0;
   assign bit_end     = bit_cnt == 16'(CLKS_PER_BIT - 1);
   assign tx_serial   = state == S_START ? 1'b0 : state == S_DATA ? shift[0] :
                        state == S_PARITY ? par_bit : 1'b1;

   always_comb begin
      state_n = state;
      pop = 1'b0;
      case (state)
         S_IDLE: begin
            pop = fifo_count != '0;
            state_n = pop ? S_START : S_IDLE;
         end
         S_START:  state_n = bit_end ? S_DATA : S_START;
         S_DATA:   state_n = (bit_end && bit_idx == 4'(DATA_BITS - 1)) ?
                             (PARITY != 0 ? S_PARITY : S_STOP) : S_DATA;
         S_PARITY: state_n = bit_end ? S_STOP : S_PARITY;
         S_STOP: begin
            // back-to-back frames: the next word is popped on the closing stop edge
            if (bit_end && bit_idx == 4'(STOP_BITS - 1)) begin
               pop = fifo_count != '0;
               state_n = pop ? S_START : S_IDLE;
            end
         end
         default:  state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_IDLE;
         bit_cnt <= '0;
         bit_idx <= '0;
         shift   <= '0;
         par_bit <= 1'b0;
      end else begin
         state   <= state_n;
         bit_cnt <= (state == S_IDLE || bit_end) ? '0 : bit_cnt + 16'd1;
         // bit_idx counts data bits in S_DATA and stop bits in S_STOP
         bit_idx <= state_n != state ? '0 : bit_end ? bit_idx + 4'd1 : bit_idx;
         shift   <= pop ? mem[rd_ptr] : (state == S_DATA && bit_end) ? shift >> 1 : shift;
         par_bit <= pop ? (^mem[rd_ptr]) ^ (PARITY == 2) : par_bit;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         wr_ptr     <= push ? wr_ptr + AW'(1) : wr_ptr;
         rd_ptr     <= pop ? rd_ptr + AW'(1) : rd_ptr;
         fifo_count <= fifo_count + (AW+1)'(push) - (AW+1)'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= tx_byte;
   end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: randomized self-checking bench for uart_tx_fifo.
// Four instances (8N1/D4, 8E1/D2, 8O1/D4, 7O2/D4) share clk and reset; a
// frame-level model predicts line, busy, ready, count and overflow each cycle.
module tb_uart_tx_fifo;
   localparam int CPB = 4;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic reset;
   logic [3:0] st, ser, busy, rdy, ovf;
   logic [8:0] by [4];
   logic [2:0] c0, c2, c3;
   logic [1:0] c1;
   int total = 0, bad = 0;
   int db [4] = '{8, 8, 8, 7};
   int pm [4] = '{0, 1, 2, 2};
   int sb [4] = '{1, 1, 1, 2};
   int dp [4] = '{4, 2, 4, 4};
   int wl [$];

   uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
      .clk(clk), .reset(reset), .tx_start(st[0]), .tx_byte(by[0][7:0]), .tx_serial(ser[0]),
      .tx_busy(busy[0]), .tx_ready(rdy[0]), .fifo_count(c0), .tx_overflow(ovf[0]));
   uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(2)) u_8e1 (
      .clk(clk), .reset(reset), .tx_start(st[1]), .tx_byte(by[1][7:0]), .tx_serial(ser[1]),
      .tx_busy(busy[1]), .tx_ready(rdy[1]), .fifo_count(c1), .tx_overflow(ovf[1]));
   uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8o1 (
      .clk(clk), .reset(reset), .tx_start(st[2]), .tx_byte(by[2][7:0]), .tx_serial(ser[2]),
      .tx_busy(busy[2]), .tx_ready(rdy[2]), .fifo_count(c2), .tx_overflow(ovf[2]));
   uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u_7o2 (
      .clk(clk), .reset(reset), .tx_start(st[3]), .tx_byte(by[3][6:0]), .tx_serial(ser[3]),
      .tx_busy(busy[3]), .tx_ready(rdy[3]), .fifo_count(c3), .tx_overflow(ovf[3]));

   function automatic int flen(input int k);
      return (1 + db[k] + (pm[k] != 0 ? 1 : 0) + sb[k]) * CPB;
   endfunction

   // line level at cycle off of a frame carrying word w: start, data LSB first, parity, stop
   function automatic logic ebit(input int k, input int w, input int off);
      int b, p;
      b = off / CPB;
      p = 0;
      for (int i = 0; i < db[k]; i++) p = p ^ ((w >> i) & 1);
      if (b == 0) return 1'b0;
      if (b <= db[k]) return 1'((w >> (b - 1)) & 1);
      if (pm[k] != 0 && b == db[k] + 1) return 1'(pm[k] == 2 ? p ^ 1 : p);
      return 1'b1;
   endfunction

   function automatic int cnt_of(input int k);
      return k == 0 ? int'(c0) : k == 1 ? int'(c1) : k == 2 ? int'(c2) : int'(c3);
   endfunction

   // pushes wl[] on consecutive cycles into instance k and checks every cycle until drained
   task automatic run(input int k, input string name);
      int n, fl, tt, occ, nfree, last, lw;
      int mq [$];
      logic e_ser, e_busy, e_ovf, pop_m, push_m;
      n = wl.size();
      fl = flen(k);
      tt = 2 + n * fl + 4;
      occ = 0;
      nfree = 0;
      last = -1;
      lw = 0;
      @(posedge clk);
      #1;
      st[k] = 1'b1;
      by[k] = 9'(wl[0]);
      for (int t = 0; t < tt; t++) begin
         pop_m = occ > 0 && t >= nfree;
         push_m = t < n && occ < dp[k];
         if (pop_m) begin
            last = t;
            lw = mq.pop_front();
            nfree = t + fl;
            occ = occ - 1;
         end
         if (push_m) begin
            mq.push_back(wl[t]);
            occ = occ + 1;
         end
         @(posedge clk);
         #1;
         st[k] = t + 1 < n;
         by[k] = t + 1 < n ? 9'(wl[t + 1]) : 9'($urandom);
         @(negedge clk);
         e_ser = (last >= 0 && t < last + fl) ? ebit(k, lw, t - last) : 1'b1;
         e_busy = occ > 0 || (last >= 0 && t < last + fl);
         e_ovf = t + 1 < n && occ >= dp[k];
         total += 5;
         if (ser[k] !== e_ser) begin
            bad++;
            $display("FAIL %s serial t=%0d got=%b exp=%b", name, t, ser[k], e_ser);
         end
         if (busy[k] !== e_busy) begin
            bad++;
            $display("FAIL %s busy t=%0d got=%b exp=%b", name, t, busy[k], e_busy);
         end
         if (cnt_of(k) !== occ) begin
            bad++;
            $display("FAIL %s count t=%0d got=%0d exp=%0d", name, t, cnt_of(k), occ);
         end
         if (rdy[k] !== (occ < dp[k])) begin
            bad++;
            $display("FAIL %s ready t=%0d got=%b exp=%b", name, t, rdy[k], occ < dp[k]);
         end
         if (ovf[k] !== e_ovf) begin
            bad++;
            $display("FAIL %s overflow t=%0d got=%b exp=%b", name, t, ovf[k], e_ovf);
         end
      end
      st[k] = 1'b0;
   endtask

   task automatic check_idle(input string name);
      for (int k = 0; k < 4; k++) begin
         total += 5;
         if (ser[k] !== 1'b1 || busy[k] !== 1'b0 || rdy[k] !== 1'b1 || cnt_of(k) !== 0 || ovf[k] !== 1'b0) begin
            bad++;
            $display("FAIL %s inst=%0d got ser=%b busy=%b rdy=%b cnt=%0d ovf=%b exp 1 0 1 0 0",
                     name, k, ser[k], busy[k], rdy[k], cnt_of(k), ovf[k]);
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      st = 4'hf;
      for (int k = 0; k < 4; k++) by[k] = 9'($urandom);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_idle("reset");
      @(posedge clk);
      #1;
      reset = 1'b0;
      st = 4'h0;
      @(negedge clk);
      check_idle("start_ignored_in_reset");
   endtask

   task automatic test_8n1();
      wl = '{8'hA5};
      run(0, "8n1_a5");
      wl = '{int'($urandom_range(0, 255))};
      run(0, "8n1_rand");
   endtask

   task automatic test_parity();
      wl = '{8'h07};
      run(1, "8e1_07");
      wl = '{8'h07};
      run(2, "8o1_07");
      wl = '{int'($urandom_range(0, 255)), int'($urandom_range(0, 255))};
      run(2, "8o1_rand");
   endtask

   task automatic test_7o2();
      wl = '{8'h55};
      run(3, "7o2_55");
   endtask

   task automatic test_back_to_back();
      wl = '{1, 2, 3};
      run(0, "b2b_123");
      wl = '{int'($urandom_range(0, 127)), int'($urandom_range(0, 127)), int'($urandom_range(0, 127))};
      run(3, "b2b_7o2");
   endtask

   task automatic test_overflow();
      wl = '{int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
             int'($urandom_range(0, 255)), int'($urandom_range(0, 255))};
      run(1, "overflow_d2");
      wl = '{1, 2, 3, 4, 5, 6, 7};
      run(0, "overflow_d4");
   endtask

   task automatic test_midframe_reset();
      @(posedge clk);
      #1;
      st[0] = 1'b1;
      by[0] = 9'h0FF;
      @(posedge clk);
      #1;
      st[0] = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      total++;
      if (busy[0] !== 1'b1) begin
         bad++;
         $display("FAIL midframe_busy got=%b exp=1", busy[0]);
      end
      @(posedge clk);
      #1;
      reset = 1'b1;
      st[0] = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      st[0] = 1'b0;
      @(negedge clk);
      check_idle("midframe_reset");
      wl = '{int'($urandom_range(0, 255))};
      run(0, "after_reset");
   endtask

   task automatic test_random();
      int k, n;
      for (int r = 0; r < 8; r++) begin
         k = int'($urandom_range(0, 3));
         n = int'($urandom_range(1, 5));
         wl = {};
         for (int i = 0; i < n; i++) wl.push_back(int'($urandom_range(0, 511)));
         run(k, "random");
      end
   endtask

   initial begin
      reset = 1'b1;
      st = 4'h0;
      for (int k = 0; k < 4; k++) by[k] = '0;
      test_reset();
      test_8n1();
      test_parity();
      test_7o2();
      test_back_to_back();
      test_overflow();
      test_midframe_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
